// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode, class-prefix, B-mux select and FSM state encodings shared by the control unit.
package cpu_pkg;
    localparam logic [4:0] OPC_NOP   = 5'b11000;
    localparam logic [4:0] OPC_STR   = 5'b11001;
    localparam logic [4:0] OPC_STM_D = 5'b11010;
    localparam logic [4:0] OPC_STM_I = 5'b11011;
    localparam logic [4:0] OPC_JMP   = 5'b11100;
    localparam logic [4:0] OPC_JZ    = 5'b11101;
    localparam logic [4:0] OPC_CALL  = 5'b11110;
    localparam logic [4:0] OPC_RETH  = 5'b11111;
    localparam logic [1:0] ALU_IMM = 2'b00;
    localparam logic [1:0] ALU_REG = 2'b01;
    localparam logic [1:0] ALU_MEM = 2'b10;
    localparam logic [1:0] CTRL    = 2'b11;
    localparam logic [1:0] INB_IMM = 2'b00;
    localparam logic [1:0] INB_REG = 2'b01;
    localparam logic [1:0] INB_MEM = 2'b10;
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_ERR} state_t;
endpackage

// File: rtl/call_stack.sv
// call_stack: synchronous LIFO of return addresses, cleared by reset or restart.
module call_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             PUSH,
    input  logic             POP,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             FULL,
    output logic             EMPTY
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      sp_q, sp_d;
    logic [AW-1:0]    rd_idx;
    logic             wr;
    always_comb begin
        FULL   = sp_q == (AW+1)'(DEPTH);
        EMPTY  = sp_q == '0;
        wr     = PUSH && !FULL && !RST && !CLR;
        rd_idx = AW'(sp_q - 1'b1);
        DOUT   = mem_q[rd_idx];
        sp_d   = (RST || CLR) ? '0 :
                 wr ? sp_q + 1'b1 :
                 (POP && !EMPTY) ? sp_q - 1'b1 : sp_q;
    end
    always_ff @(posedge CLK) sp_q <= sp_d;
    always_ff @(posedge CLK) if (wr) mem_q[sp_q[AW-1:0]] <= DIN;
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: PC, single-cycle instruction decode and RUN/HALT/ERR sequencing for the accumulator datapath.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int IWIDTH         = 5,
    parameter int REG_F_SEL_SIZE = 4,
    parameter int IN_B_SEL_SIZE  = 2,
    parameter int STACK_DEPTH    = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RUN_EN,
    input  logic                      START,
    input  logic [IWIDTH+WIDTH-1:0]   INSTR,
    input  logic                      ACC_Z,
    output logic [WIDTH-1:0]          PC_ADDR,
    output logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
    output logic                      EN_REG_F,
    output logic [WIDTH-1:0]          D_MEM_ADDR,
    output logic                      D_MEM_ADDR_MODE,
    output logic                      EN_D_MEM,
    output logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL,
    output logic [WIDTH-1:0]          IMM,
    output logic [IWIDTH-2:0]         ALU_OUT,
    output logic                      EN_ACC,
    output logic                      HALTED,
    output logic                      ERR
);
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d, ret_addr;
    logic [IWIDTH-1:0] opc;
    logic [WIDTH-1:0]  opd;
    logic [1:0]        cls;
    logic              exec, is_call, is_ret, is_hlt, fault, restart, full, empty;
    always_comb begin
        opc     = INSTR[IWIDTH+WIDTH-1:WIDTH];
        opd     = INSTR[WIDTH-1:0];
        cls     = opc[IWIDTH-1:IWIDTH-2];
        exec    = state_q == ST_RUN && RUN_EN && !RST;
        is_call = opc == OPC_CALL;
        is_ret  = opc == OPC_RETH && !opd[0];
        is_hlt  = opc == OPC_RETH && opd[0];
        fault   = exec && ((is_call && full) || (is_ret && empty));
        restart = state_q == ST_HALT && START;
    end
    call_stack #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (restart),
        .PUSH  (exec && is_call),
        .POP   (exec && is_ret),
        .DIN   (pc_q + 1'b1),
        .DOUT  (ret_addr),
        .FULL  (full),
        .EMPTY (empty)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    always_comb begin
        state_d = (exec && is_hlt) ? ST_HALT :
                  fault ? ST_ERR :
                  restart ? ST_RUN : state_q;
        pc_d    = restart ? '0 :
                  (!exec || fault || is_hlt) ? pc_q :
                  (opc == OPC_JMP || is_call || (opc == OPC_JZ && ACC_Z)) ? opd :
                  is_ret ? ret_addr : pc_q + 1'b1;
    end
    always_comb begin
        PC_ADDR         = pc_q;
        REG_F_SEL       = opd[REG_F_SEL_SIZE-1:0];
        D_MEM_ADDR      = opd;
        IMM             = opd;
        ALU_OUT         = {{(IWIDTH-4){1'b0}}, opc[2:0]};
        IN_B_SEL        = cls == ALU_REG ? INB_REG : cls == ALU_MEM ? INB_MEM : INB_IMM;
        D_MEM_ADDR_MODE = opc == OPC_STM_I;
        EN_ACC          = exec && cls != CTRL;
        EN_REG_F        = exec && opc == OPC_STR;
        EN_D_MEM        = exec && (opc == OPC_STM_D || opc == OPC_STM_I);
        HALTED          = state_q == ST_HALT;
        ERR             = state_q == ST_ERR;
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: table-driven directed vectors for cpu_ctrl decode, sequencing and stack corner cases.
module tb_cpu_ctrl;
    logic        CLK = 0, RST, RUN_EN, START, ACC_Z;
    logic [12:0] INSTR;
    logic [7:0]  PC_ADDR, D_MEM_ADDR, IMM;
    logic [3:0]  REG_F_SEL, ALU_OUT;
    logic [1:0]  IN_B_SEL;
    logic        EN_REG_F, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC, HALTED, ERR;
    int          n_tests = 0, n_fail = 0, vidx = 0;

    cpu_ctrl dut (
        .CLK(CLK), .RST(RST), .RUN_EN(RUN_EN), .START(START), .INSTR(INSTR), .ACC_Z(ACC_Z),
        .PC_ADDR(PC_ADDR), .REG_F_SEL(REG_F_SEL), .EN_REG_F(EN_REG_F), .D_MEM_ADDR(D_MEM_ADDR),
        .D_MEM_ADDR_MODE(D_MEM_ADDR_MODE), .EN_D_MEM(EN_D_MEM), .IN_B_SEL(IN_B_SEL), .IMM(IMM),
        .ALU_OUT(ALU_OUT), .EN_ACC(EN_ACC), .HALTED(HALTED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [12:0] i;
        logic        az, run, st, r;
        logic [7:0]  pc0;
        logic [1:0]  inb;
        logic        mode, erf, edm, eacc;
        logic [7:0]  pc1;
        logic        h, e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [12:0] i, input logic az, run, st, r,
                               input logic [7:0] pc0, input logic [1:0] inb,
                               input logic mode, erf, edm, eacc,
                               input logic [7:0] pc1, input logic h, e);
        vec_t t;
        t.i = i; t.az = az; t.run = run; t.st = st; t.r = r; t.pc0 = pc0; t.inb = inb;
        t.mode = mode; t.erf = erf; t.edm = edm; t.eacc = eacc; t.pc1 = pc1; t.h = h; t.e = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h expected %h", vidx, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        logic [23:0] pass;
        @(negedge CLK);
        INSTR = t.i; ACC_Z = t.az; RUN_EN = t.run; START = t.st; RST = t.r;
        #1;
        pass = {t.i[3:0], t.i[7:0], t.i[7:0], 1'b0, t.i[10:8]};
        chk("pc_pre", 32'(PC_ADDR), 32'(t.pc0));
        chk("ctrl", 32'({IN_B_SEL, D_MEM_ADDR_MODE, EN_REG_F, EN_D_MEM, EN_ACC}),
            32'({t.inb, t.mode, t.erf, t.edm, t.eacc}));
        chk("pass", 32'({REG_F_SEL, D_MEM_ADDR, IMM, ALU_OUT}), 32'(pass));
        @(posedge CLK);
        #1;
        chk("pc_post", 32'(PC_ADDR), 32'(t.pc1));
        chk("state", 32'({HALTED, ERR}), 32'({t.h, t.e}));
        vidx++;
    endtask

    initial begin
        RST = 1; RUN_EN = 1; START = 0; ACC_Z = 0; INSTR = {5'b00011, 8'h05};
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc", 32'(PC_ADDR), 32'h0);
        chk("rst_state", 32'({HALTED, ERR}), 32'h0);
        chk("rst_en", 32'({EN_ACC, EN_REG_F, EN_D_MEM}), 32'h0);
        // decode classes, stall, branches, wrap, call/return, underflow
        tbl.push_back(v({5'b00011, 8'h05}, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 1, 8'h01, 0, 0));
        tbl.push_back(v({5'b01010, 8'h03}, 0, 1, 0, 0, 8'h01, 2'b01, 0, 0, 0, 1, 8'h02, 0, 0));
        tbl.push_back(v({5'b10001, 8'h30}, 0, 1, 0, 0, 8'h02, 2'b10, 0, 0, 0, 1, 8'h03, 0, 0));
        tbl.push_back(v({5'b11001, 8'h04}, 0, 1, 0, 0, 8'h03, 2'b00, 0, 1, 0, 0, 8'h04, 0, 0));
        tbl.push_back(v({5'b11010, 8'h10}, 0, 1, 0, 0, 8'h04, 2'b00, 0, 0, 1, 0, 8'h05, 0, 0));
        tbl.push_back(v({5'b11011, 8'h02}, 0, 1, 0, 0, 8'h05, 2'b00, 1, 0, 1, 0, 8'h06, 0, 0));
        tbl.push_back(v({5'b11011, 8'h02}, 0, 0, 0, 0, 8'h06, 2'b00, 1, 0, 0, 0, 8'h06, 0, 0));
        tbl.push_back(v({5'b11000, 8'h00}, 0, 1, 0, 0, 8'h06, 2'b00, 0, 0, 0, 0, 8'h07, 0, 0));
        tbl.push_back(v({5'b11101, 8'h40}, 0, 1, 0, 0, 8'h07, 2'b00, 0, 0, 0, 0, 8'h08, 0, 0));
        tbl.push_back(v({5'b11100, 8'h07}, 0, 1, 0, 0, 8'h08, 2'b00, 0, 0, 0, 0, 8'h07, 0, 0));
        tbl.push_back(v({5'b11101, 8'h40}, 1, 1, 0, 0, 8'h07, 2'b00, 0, 0, 0, 0, 8'h40, 0, 0));
        tbl.push_back(v({5'b11100, 8'hFF}, 0, 1, 0, 0, 8'h40, 2'b00, 0, 0, 0, 0, 8'hFF, 0, 0));
        tbl.push_back(v({5'b11000, 8'h00}, 0, 1, 0, 0, 8'hFF, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v({5'b00000, 8'h00}, 0, 1, 1, 0, 8'h00, 2'b00, 0, 0, 0, 1, 8'h01, 0, 0));
        tbl.push_back(v({5'b11100, 8'h03}, 0, 1, 0, 0, 8'h01, 2'b00, 0, 0, 0, 0, 8'h03, 0, 0));
        tbl.push_back(v({5'b11110, 8'h20}, 0, 1, 0, 0, 8'h03, 2'b00, 0, 0, 0, 0, 8'h20, 0, 0));
        tbl.push_back(v({5'b11111, 8'h00}, 0, 1, 0, 0, 8'h20, 2'b00, 0, 0, 0, 0, 8'h04, 0, 0));
        tbl.push_back(v({5'b11111, 8'h00}, 0, 1, 0, 0, 8'h04, 2'b00, 0, 0, 0, 0, 8'h04, 0, 1));
        tbl.push_back(v({5'b00000, 8'h00}, 0, 1, 1, 0, 8'h04, 2'b00, 0, 0, 0, 0, 8'h04, 0, 1));
        foreach (tbl[k]) apply(tbl[k]);
        // reset out of ERR, then nested calls return in LIFO order
        apply(v({5'b00000, 8'h00}, 0, 1, 0, 1, 8'h04, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0));
        apply(v({5'b11100, 8'h05}, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h05, 0, 0));
        apply(v({5'b11110, 8'h10}, 0, 1, 0, 0, 8'h05, 2'b00, 0, 0, 0, 0, 8'h10, 0, 0));
        apply(v({5'b11110, 8'h20}, 0, 1, 0, 0, 8'h10, 2'b00, 0, 0, 0, 0, 8'h20, 0, 0));
        apply(v({5'b11111, 8'h00}, 0, 1, 0, 0, 8'h20, 2'b00, 0, 0, 0, 0, 8'h11, 0, 0));
        apply(v({5'b11111, 8'h00}, 0, 1, 0, 0, 8'h11, 2'b00, 0, 0, 0, 0, 8'h06, 0, 0));
        // four pushes fill the stack (self-calls included), the fifth overflows
        apply(v({5'b11110, 8'h00}, 0, 1, 0, 0, 8'h06, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0));
        for (int k = 0; k < 3; k++)
            apply(v({5'b11110, 8'h00}, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0));
        apply(v({5'b11110, 8'h30}, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00, 0, 1));
        apply(v({5'b00000, 8'h00}, 0, 1, 1, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00, 0, 1));
        apply(v({5'b00000, 8'h00}, 0, 1, 0, 1, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0));
        // halt, stay halted, restart with RUN_EN low
        apply(v({5'b11100, 8'h09}, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h09, 0, 0));
        apply(v({5'b11111, 8'h01}, 0, 1, 0, 0, 8'h09, 2'b00, 0, 0, 0, 0, 8'h09, 1, 0));
        apply(v({5'b00000, 8'h00}, 0, 1, 0, 0, 8'h09, 2'b00, 0, 0, 0, 0, 8'h09, 1, 0));
        apply(v({5'b11000, 8'h00}, 0, 0, 1, 0, 8'h09, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0));
        apply(v({5'b11000, 8'h00}, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h01, 0, 0));
        // reset during CALL leaves the stack empty, so the next RET underflows
        apply(v({5'b11100, 8'h03}, 0, 1, 0, 0, 8'h01, 2'b00, 0, 0, 0, 0, 8'h03, 0, 0));
        apply(v({5'b11110, 8'h20}, 0, 1, 0, 1, 8'h03, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0));
        apply(v({5'b11111, 8'h00}, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00, 0, 1));
        apply(v({5'b00000, 8'h00}, 0, 1, 0, 1, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
